cnn_frame_loader: RTL and testbench
===================================

CNN_FRAME_LOADER -- requirements
Module: cnn_frame_loader

Interface
REQ-001 Parameter DWIDTH, default 32: pixel/data word width.
REQ-002 Parameter WIDTH, default 320: pixels per row.
REQ-003 Parameter HEIGHT, default 240: rows per frame.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 s_valid  input  1  upstream pixel valid.
REQ-007 s_ready  output  1  loader accepts pixel; transfer = s_valid & s_ready.
REQ-008 s_data  input  DWIDTH  pixel value.
REQ-009 s_sof  input  1  start-of-frame marker, qualified by transfer.
REQ-010 s_eol  input  1  end-of-line marker, qualified by transfer.
REQ-011 en_w1_n  output  1  frame memory write enable, active-low.
REQ-012 waddr_w1  output  $clog2(WIDTH)  column write address.
REQ-013 haddr_w1  output  $clog2(HEIGHT)  row write address.
REQ-014 data_w1  output  DWIDTH  write data.
REQ-015 consume_done  input  1  one-cycle pulse from downstream copy FSM: frame read out, buffer free.
REQ-016 frame_done  output  1  one-cycle pulse: full frame written.
REQ-017 line_err  output  1  one-cycle pulse on line-length violation.
REQ-018 err_cnt  output  8  line error count.

Function
REQ-019 States SHALL be IDLE, FILL, WAIT_CONSUME; one-hot encoded.
REQ-020 s_ready SHALL be 1 in IDLE and FILL, 0 in WAIT_CONSUME; decoded from state only, no combinational path from s_valid.
REQ-021 IDLE: transfer without s_sof SHALL be dropped, no write; transfer with s_sof SHALL be written at (col 0,row 0), next state FILL.
REQ-022 Writes SHALL be registered: transfer in cycle t gives en_w1_n=0 with waddr_w1/haddr_w1/data_w1 valid in t+1; otherwise en_w1_n=1.
REQ-023 Column counter SHALL increment per accepted pixel; row advances and column returns to 0 on s_eol or at col==WIDTH-1, whichever first.
REQ-024 s_eol with col<WIDTH-1 (short line) SHALL pulse line_err; row advances.
REQ-025 Pixel at col==WIDTH-1 without s_eol (long line) SHALL pulse line_err; row advances.
REQ-026 s_sof in FILL SHALL restart the frame: pixel written at (0,0), counters reset, no line_err.
REQ-027 Write at (WIDTH-1 or eol, HEIGHT-1) SHALL end the frame: frame_done=1 in the same cycle as that write's en_w1_n=0; state becomes WAIT_CONSUME.
REQ-028 WAIT_CONSUME: consume_done SHALL move to IDLE next cycle; consume_done in IDLE/FILL SHALL be ignored.
REQ-029 line_err pulse and frame_done pulse MAY coincide on last pixel.
REQ-030 Counter widths SHALL be $clog2(WIDTH)/$clog2(HEIGHT); no wrap beyond WIDTH-1/HEIGHT-1.

Reset
REQ-031 reset_n=0 SHALL force state IDLE, counters 0, en_w1_n=1, addresses 0, data_w1 0, frame_done 0, line_err 0, err_cnt 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done; next frame requires new s_sof.

Configuration
REQ-033 With CNN_LOADER_ERRCNT_EN defined, err_cnt SHALL increment on each line_err, saturating at 255, cleared only by reset.
REQ-034 Without CNN_LOADER_ERRCNT_EN, err_cnt SHALL be constant 0 and no counter logic synthesized; line_err unaffected.

Structure
REQ-035 Shared package cnn_accel_pkg SHALL hold state encodings and default DWIDTH/WIDTH/HEIGHT constants.
REQ-036 Block SHALL be flat; no sub-module. Output memory port feeds the frame memory read by cnn_accel_fsm; its done drives consume_done.

Verification (WIDTH=4, HEIGHT=3, DWIDTH=8)
REQ-037 12 clean pixels 0x00..0x0B, sof on first, eol every 4th -> writes (c,r) row-major, frame_done with write of 0x0B at (3,2), s_ready=0 after.
REQ-038 Row 1 eol after 2 pixels -> line_err once, next pixel written at (0,2), err_cnt=1 (macro on) / 0 (off).
REQ-039 Pixels without sof in IDLE -> no writes; following sof pixel at (0,0).
REQ-040 sof at (2,1) mid-frame -> write at (0,0), frame completes 12 pixels later.
REQ-041 WAIT_CONSUME, s_valid held 1 for 10 cycles -> no writes; consume_done pulse -> s_ready=1 next cycle.
REQ-042 reset_n=0 at (1,1) -> all outputs reset values, no frame_done; new frame loads normally.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// ---------------------------------------------------------------------------
// cnn_accel_pkg
//   Shared constants for the CNN accelerator front end.
//   - Default frame geometry and pixel width used by cnn_frame_loader.
//   - One-hot state encodings of the frame loader FSM, plus the bit index
//     of each state so that decodes can test a single flop.
//   - Saturating 8-bit increment helper used by the optional error counter.
// ---------------------------------------------------------------------------
package cnn_accel_pkg;

  // Default geometry: 320x240 frames of 32-bit pixels.
  localparam int DWIDTH_DEF = 32;
  localparam int WIDTH_DEF  = 320;
  localparam int HEIGHT_DEF = 240;

  // Loader FSM, one-hot. Kept as plain localparam vectors so older tools and
  // the existing netlists that probe the state flops see the same encoding.
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE         = 3'b001;
  localparam logic [ST_W-1:0] ST_FILL         = 3'b010;
  localparam logic [ST_W-1:0] ST_WAIT_CONSUME = 3'b100;

  localparam int ST_IDLE_BIT = 0;
  localparam int ST_FILL_BIT = 1;
  localparam int ST_WAIT_BIT = 2;

  // Saturating increment: 255 stays at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : cnn_accel_pkg

// File: rtl/cnn_frame_loader.sv
// ---------------------------------------------------------------------------
// cnn_frame_loader
//   Takes a pixel stream (valid/ready with start-of-frame and end-of-line
//   markers) and writes one frame into the frame memory that cnn_accel_fsm
//   reads. Once a full frame is written the loader stalls the stream until
//   the downstream copy FSM reports the buffer free (consume_done).
//
//   Row/column positions come from internal counters; the stream markers
//   only resynchronise them. A line that ends early (s_eol before the last
//   column) or runs long (last column reached without s_eol) is flagged on
//   line_err and the row advances either way, so a bad line never shifts
//   the rest of the frame.
//
// Parameters
//   DWIDTH  pixel width
//   WIDTH   pixels per row  (>= 2)
//   HEIGHT  rows per frame  (>= 2)
//
// Ports
//   clk           clock, rising edge
//   reset_n       synchronous, active-low reset
//   s_valid       upstream pixel valid
//   s_ready       loader can take a pixel (state decode only)
//   s_data        pixel value
//   s_sof         start of frame, qualified by transfer
//   s_eol         end of line, qualified by transfer
//   en_w1_n       frame memory write enable, active-low (registered)
//   waddr_w1      column write address
//   haddr_w1      row write address
//   data_w1       write data
//   consume_done  pulse from downstream: frame read out, buffer free
//   frame_done    pulse, coincident with the last write of a frame
//   line_err      pulse, coincident with the write that closed a bad line
//   err_cnt       line error count
//
// Build option
//   CNN_LOADER_ERRCNT_EN : when defined, err_cnt counts line_err pulses
//   (saturating at 255, cleared by reset only). When undefined err_cnt is
//   tied to 0 and no counter exists.
// ---------------------------------------------------------------------------
module cnn_frame_loader
  import cnn_accel_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,

  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DWIDTH-1:0]         s_data,
  input  logic                      s_sof,
  input  logic                      s_eol,

  output logic                      en_w1_n,
  output logic [$clog2(WIDTH)-1:0]  waddr_w1,
  output logic [$clog2(HEIGHT)-1:0] haddr_w1,
  output logic [DWIDTH-1:0]         data_w1,

  input  logic                      consume_done,
  output logic                      frame_done,
  output logic                      line_err,
  output logic [7:0]                err_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  // -------------------------------------------------------------------------
  // State and registers
  // -------------------------------------------------------------------------
  logic [ST_W-1:0]   state_q,      state_d;
  logic [CW-1:0]     col_q,        col_d;
  logic [RW-1:0]     row_q,        row_d;

  logic              en_n_q,       en_n_d;
  logic [CW-1:0]     waddr_q,      waddr_d;
  logic [RW-1:0]     haddr_q,      haddr_d;
  logic [DWIDTH-1:0] data_q,       data_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q,   line_err_d;

  // Ready is a pure state decode so there is no path from s_valid to s_ready.
  assign s_ready = state_q[ST_IDLE_BIT] | state_q[ST_FILL_BIT];

  // -------------------------------------------------------------------------
  // Per-pixel position decode
  // -------------------------------------------------------------------------
  logic          xfer;
  logic          accept;
  logic [CW-1:0] pix_col;
  logic [RW-1:0] pix_row;
  logic          at_col_last;
  logic          at_row_last;
  logic          line_end;

  assign xfer = s_valid & s_ready;

  // In IDLE only a start-of-frame pixel is taken; anything else is dropped
  // so a loader that came up mid-stream waits for a clean frame boundary.
  assign accept = xfer & (state_q[ST_FILL_BIT] | (state_q[ST_IDLE_BIT] & s_sof));

  // A start-of-frame pixel always lands at (0,0), whatever the counters say;
  // this is what makes s_sof in FILL a clean restart.
  assign pix_col = s_sof ? '0 : col_q;
  assign pix_row = s_sof ? '0 : row_q;

  assign at_col_last = (pix_col == COL_LAST);
  assign at_row_last = (pix_row == ROW_LAST);

  // A line closes on whichever comes first: the marker or the last column.
  assign line_end = s_eol | at_col_last;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    en_n_d       = 1'b1;
    waddr_d      = waddr_q;
    haddr_d      = haddr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          en_n_d  = 1'b0;
          waddr_d = pix_col;
          haddr_d = pix_row;
          data_d  = s_data;
          state_d = ST_FILL;

          // Marker and column count disagree -> short or long line. A
          // start-of-frame pixel opens a fresh frame and is never an error.
          line_err_d = ~s_sof & (s_eol ^ at_col_last);

          if (line_end) begin
            col_d = '0;
            if (at_row_last) begin
              row_d        = '0;
              frame_done_d = 1'b1;
              state_d      = ST_WAIT_CONSUME;
            end else begin
              row_d = pix_row + 1'b1;
            end
          end else begin
            col_d = pix_col + 1'b1;
            row_d = pix_row;
          end
        end
      end

      ST_WAIT_CONSUME: begin
        if (consume_done) begin
          state_d = ST_IDLE;
        end
      end

      // Any non one-hot pattern (upset) falls back to waiting for a new frame.
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      en_n_q       <= 1'b1;
      waddr_q      <= '0;
      haddr_q      <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      en_n_q       <= en_n_d;
      waddr_q      <= waddr_d;
      haddr_q      <= haddr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
    end
  end

  assign en_w1_n    = en_n_q;
  assign waddr_w1   = waddr_q;
  assign haddr_w1   = haddr_q;
  assign data_w1    = data_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;

  // -------------------------------------------------------------------------
  // Optional line error counter
  // -------------------------------------------------------------------------
`ifdef CNN_LOADER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts on the same edge that raises line_err, so the new count is
  // visible together with the pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= 8'd0;
    end else if (line_err_d) begin
      err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule : cnn_frame_loader

// File: tb/tb_cnn_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_cnn_frame_loader
//   Table-driven check of cnn_frame_loader with WIDTH=4, HEIGHT=3, DWIDTH=8.
//   Each table row holds the inputs for one clock and the outputs expected
//   just after that clock edge. Rows are built by short sequences covering:
//   reset, drop-before-sof, a clean frame, back-pressure in WAIT_CONSUME,
//   consume_done handling, short and long lines, sof restart mid-frame and
//   reset mid-frame.
// ---------------------------------------------------------------------------
module tb_cnn_frame_loader;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

`ifdef CNN_LOADER_ERRCNT_EN
  localparam bit EC_ON = 1'b1;
`else
  localparam bit EC_ON = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;
  logic          en_w1_n;
  logic [1:0]    waddr_w1;
  logic [1:0]    haddr_w1;
  logic [DW-1:0] data_w1;
  logic          consume_done;
  logic          frame_done;
  logic          line_err;
  logic [7:0]    err_cnt;

  cnn_frame_loader #(
    .DWIDTH (DW),
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_eol        (s_eol),
    .en_w1_n      (en_w1_n),
    .waddr_w1     (waddr_w1),
    .haddr_w1     (haddr_w1),
    .data_w1      (data_w1),
    .consume_done (consume_done),
    .frame_done   (frame_done),
    .line_err     (line_err),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // inputs
    logic          rst_n;
    logic          valid;
    logic          sof;
    logic          eol;
    logic          cdone;
    logic [DW-1:0] din;
    // expected outputs after the edge
    logic          rdy;
    logic          en_n;
    logic [1:0]    wa;
    logic [1:0]    ha;
    logic [DW-1:0] dout;
    logic          fd;
    logic          le;
    logic [7:0]    ec;        // count with counter enabled
    logic          chk_addr;  // compare address/data fields
  } vec_t;

  vec_t vecs[$];

  int tests = 0;
  int fails = 0;

  task automatic add(input logic rst_n, input logic valid, input logic sof,
                     input logic eol, input logic cdone, input logic [DW-1:0] din,
                     input logic rdy, input logic en_n, input logic [1:0] wa,
                     input logic [1:0] ha, input logic [DW-1:0] dout,
                     input logic fd, input logic le, input logic [7:0] ec,
                     input logic chk_addr);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.sof = sof; v.eol = eol; v.cdone = cdone;
    v.din = din; v.rdy = rdy; v.en_n = en_n; v.wa = wa; v.ha = ha; v.dout = dout;
    v.fd = fd; v.le = le; v.ec = ec; v.chk_addr = chk_addr;
    vecs.push_back(v);
  endtask

  // Accepted pixel written at (wa,ha); ready drops only after the last write.
  task automatic add_pix(input logic [DW-1:0] din, input logic sof, input logic eol,
                         input logic [1:0] wa, input logic [1:0] ha,
                         input logic fd, input logic le, input logic [7:0] ec);
    add(1, 1, sof, eol, 0, din, !fd, 0, wa, ha, din, fd, le, ec, 1);
  endtask

  // Cycle with no accepted pixel (valid may be high while stalled/dropped).
  task automatic add_nowr(input logic valid, input logic sof, input logic cdone,
                          input logic [DW-1:0] din, input logic rdy, input logic [7:0] ec);
    add(1, valid, sof, 0, cdone, din, rdy, 1, 0, 0, 0, 0, 0, ec, 0);
  endtask

  // Clean 12-pixel frame, sof on the first, eol on every 4th.
  task automatic add_frame(input logic [DW-1:0] base, input logic [7:0] ec);
    for (int i = 0; i < 12; i++) begin
      add_pix(base + DW'(i), i == 0, (i % 4) == 3, 2'(i % 4), 2'(i / 4), i == 11, 0, ec);
    end
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL vec %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    s_sof        = 1'b0;
    s_eol        = 1'b0;
    consume_done = 1'b0;

    // --- reset state (valid high during reset must not write)
    add(0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 8'h77, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);

    // --- IDLE: pixels without sof are dropped, addresses untouched
    add(1, 1, 0, 0, 0, 8'h55, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 8'h66, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);
    // consume_done in IDLE is ignored
    add_nowr(0, 0, 1, 8'h00, 1, 0);

    // --- clean frame 0x00..0x0B
    add_frame(8'h00, 0);

    // --- WAIT_CONSUME: valid held for 10 cycles, nothing written
    for (int i = 0; i < 10; i++) add_nowr(1, i == 3, 0, 8'hAA, 0, 0);
    // consume_done releases the buffer; ready is back next cycle
    add_nowr(0, 0, 1, 8'h00, 1, 0);

    // --- short line in row 1
    add_pix(8'h10, 1, 0, 0, 0, 0, 0, 0);
    add_pix(8'h11, 0, 0, 1, 0, 0, 0, 0);
    add_pix(8'h12, 0, 0, 2, 0, 0, 0, 0);
    add_pix(8'h13, 0, 1, 3, 0, 0, 0, 0);
    add_pix(8'h14, 0, 0, 0, 1, 0, 0, 0);
    add_pix(8'h15, 0, 1, 1, 1, 0, 1, 1);   // eol at col 1 -> line_err
    add_pix(8'h16, 0, 0, 0, 2, 0, 0, 1);   // next pixel starts row 2
    // consume_done while filling is ignored (pixel still taken)
    add(1, 1, 0, 0, 1, 8'h17, 1, 0, 1, 2, 8'h17, 0, 0, 1, 1);
    add_nowr(0, 0, 0, 8'h00, 1, 1);        // bubble: no write
    add_pix(8'h18, 0, 0, 2, 2, 0, 0, 1);
    add_pix(8'h19, 0, 1, 3, 2, 1, 0, 1);   // frame ends
    add_nowr(1, 0, 0, 8'hBB, 0, 1);
    add_nowr(0, 0, 1, 8'h00, 1, 1);

    // --- long line in row 0, then sof restart at (2,1)
    add_pix(8'h20, 1, 0, 0, 0, 0, 0, 1);
    add_pix(8'h21, 0, 0, 1, 0, 0, 0, 1);
    add_pix(8'h22, 0, 0, 2, 0, 0, 0, 1);
    add_pix(8'h23, 0, 0, 3, 0, 0, 1, 2);   // last column, no eol -> line_err
    add_pix(8'h24, 0, 0, 0, 1, 0, 0, 2);
    add_pix(8'h25, 0, 0, 1, 1, 0, 0, 2);
    add_frame(8'h30, 2);                   // sof at (2,1) restarts at (0,0)
    add_nowr(0, 0, 1, 8'h00, 1, 2);

    // --- reset mid-frame at (1,1)
    add_pix(8'h40, 1, 0, 0, 0, 0, 0, 2);
    add_pix(8'h41, 0, 0, 1, 0, 0, 0, 2);
    add_pix(8'h42, 0, 0, 2, 0, 0, 0, 2);
    add_pix(8'h43, 0, 1, 3, 0, 0, 0, 2);
    add_pix(8'h44, 0, 0, 0, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 8'h45, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);
    // frame abandoned: pixels without sof are dropped
    add(1, 1, 0, 0, 0, 8'h46, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 8'h47, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1);
    add_frame(8'h50, 0);
    add_nowr(0, 0, 1, 8'h00, 1, 0);

    // --- apply
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      int   exp_ec;
      v = vecs[i];
      @(negedge clk);
      reset_n      = v.rst_n;
      s_valid      = v.valid;
      s_sof        = v.sof;
      s_eol        = v.eol;
      consume_done = v.cdone;
      s_data       = v.din;
      @(posedge clk);
      #1;
      exp_ec = EC_ON ? int'(v.ec) : 0;
      $display("[TB] vec %0d rst_n=%0b v=%0b sof=%0b eol=%0b cd=%0b d=%02h -> rdy=%0b en_n=%0b (%0d,%0d) q=%02h fd=%0b le=%0b ec=%0d",
               i, v.rst_n, v.valid, v.sof, v.eol, v.cdone, v.din,
               s_ready, en_w1_n, waddr_w1, haddr_w1, data_w1, frame_done, line_err, err_cnt);
      chk("s_ready",    i, int'(s_ready),    int'(v.rdy));
      chk("en_w1_n",    i, int'(en_w1_n),    int'(v.en_n));
      chk("frame_done", i, int'(frame_done), int'(v.fd));
      chk("line_err",   i, int'(line_err),   int'(v.le));
      chk("err_cnt",    i, int'(err_cnt),    exp_ec);
      if (v.chk_addr) begin
        chk("waddr_w1", i, int'(waddr_w1), int'(v.wa));
        chk("haddr_w1", i, int'(haddr_w1), int'(v.ha));
        chk("data_w1",  i, int'(data_w1),  int'(v.dout));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cnn_frame_loader
